w_seq_mag_cmp: RTL

//  Sequential multi-digit magnitude comparator. Latches two DIGITS-nibble operands on START.

---
 rtl/w_seq_mag_cmp_pkg.sv | 17 +
 rtl/w_seq_mag_cmp_if.sv | 29 ++
 rtl/w_seq_mag_cmp_nib_cmp.sv | 16 +
 rtl/w_seq_mag_cmp.sv | 114 +++++++++++
 4 files changed

// File: rtl/w_seq_mag_cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Holds FSM state codes, nibble width and the index-width helper.
package w_seq_mag_cmp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // A single-digit comparator still needs a 1-bit index register.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/w_seq_mag_cmp_if.sv
// Request/result bundle between a requester and w_seq_mag_cmp.
// The master issues operands and start; the slave returns status and the result.
interface w_seq_mag_cmp_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic [4*DIGITS-1:0]   a_in;
  logic [4*DIGITS-1:0]   b_in;
  logic                  iagb;
  logic                  iasb;
  logic                  iaeb;
  logic                  busy;
  logic                  done;
  logic                  qagb;
  logic                  qasb;
  logic                  qaeb;

  modport master (
    output start, a_in, b_in, iagb, iasb, iaeb,
    input  busy, done, qagb, qasb, qaeb
  );

  modport slave (
    input  start, a_in, b_in, iagb, iasb, iaeb,
    output busy, done, qagb, qasb, qaeb
  );

endinterface

// File: rtl/w_seq_mag_cmp_nib_cmp.sv
// Combinational 4-bit unsigned magnitude compare; exactly one of gt/lt/eq is high.
module w_nib_cmp
  import w_seq_mag_cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/w_seq_mag_cmp.sv
// Sequential multi-digit magnitude comparator: one nibble pair per clock, MSB first,
// stopping at the first difference, else resolving from the latched cascade inputs.
module w_seq_mag_cmp
  import w_seq_mag_cmp_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  w_seq_mag_cmp_if.slave bus
);

  localparam int IDX_W = idx_width(DIGITS);

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [DIGITS-1:0][NIB_W-1:0]    a_q;
  logic [DIGITS-1:0][NIB_W-1:0]    b_q;
  logic                            cas_gb;
  logic                            cas_sb;
  logic                            cas_eb;
  logic                            busy;
  logic                            done;
  logic                            qagb;
  logic                            qasb;
  logic                            qaeb;

  logic [NIB_W-1:0]                a_nib;
  logic [NIB_W-1:0]                b_nib;
  logic                            nib_gt;
  logic                            nib_lt;
  logic                            nib_eq;

  assign a_nib = a_q[idx];
  assign b_nib = b_q[idx];

  w_nib_cmp u_nib_cmp (
    .a  (a_nib),
    .b  (b_nib),
    .gt (nib_gt),
    .lt (nib_lt),
    .eq (nib_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cas_gb <= 1'b0;
      cas_sb <= 1'b0;
      cas_eb <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      qagb   <= 1'b0;
      qasb   <= 1'b0;
      qaeb   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a_in;
            b_q    <= bus.b_in;
            cas_gb <= bus.iagb;
            cas_sb <= bus.iasb;
            cas_eb <= bus.iaeb;
            idx    <= IDX_W'(DIGITS - 1);
            qagb   <= 1'b0;
            qasb   <= 1'b0;
            qaeb   <= 1'b0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (!nib_eq) begin
            qagb  <= nib_gt;
            qasb  <= nib_lt;
            qaeb  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (idx != '0) begin
            idx <= idx - IDX_W'(1);
          end else begin
            // All nibbles equal: cascade inputs decide, IAEB has top priority.
            if (cas_eb) begin
              qagb <= 1'b0;
              qasb <= 1'b0;
              qaeb <= 1'b1;
            end else begin
              qagb <= (cas_gb == cas_sb) ? ~cas_gb : cas_gb;
              qasb <= (cas_gb == cas_sb) ? ~cas_sb : cas_sb;
              qaeb <= 1'b0;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.qagb = qagb;
  assign bus.qasb = qasb;
  assign bus.qaeb = qaeb;

endmodule
